// File: rtl/tone_rom_player_pkg.sv
// rtl/tone_rom_player_pkg.sv - state encoding, sample field layout and gain helper for tone_rom_player
package tone_rom_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int LEFT_MSB        = 31;
  localparam int LEFT_LSB        = 16;
  localparam int RIGHT_MSB       = 15;
  localparam int RIGHT_LSB       = 0;
  localparam int DEFAULT_CLK_DIV = 1042;

  // Arithmetic shift keeps the sign, so a shift of 15 collapses to 0 or -1.
  function automatic logic [15:0] sra_half(input logic [15:0] x, input logic [3:0] sh);
    sra_half = 16'($signed(x) >>> sh);
  endfunction

endpackage

// File: rtl/tone_tick_div.sv
// rtl/tone_tick_div.sv - sample-rate divider with enable and synchronous restart
module tone_tick_div
  import tone_rom_player_pkg::*;
#(
  parameter int DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_rom_player.sv
// rtl/tone_rom_player.sv - steps a tone ROM at the sample rate into a one-entry valid/ready buffer
// Define TONE_ROM_PLAYER_GAIN_EN to add gain_shift_i, an arithmetic right shift on each half.
module tone_rom_player
  import tone_rom_player_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int REP_WIDTH  = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  input  logic [REP_WIDTH-1:0]  rep_count_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
`ifdef TONE_ROM_PLAYER_GAIN_EN
  input  logic [3:0]            gain_shift_i,
`endif
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           underrun_cnt_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REP_WIDTH-1:0]  pass_q, pass_d;
  logic [REP_WIDTH-1:0]  target_q, target_d;
  logic                  loop_q, loop_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [15:0]           under_q, under_d;

  logic                  tick;
  logic                  div_restart;
  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;

`ifdef TONE_ROM_PLAYER_GAIN_EN
  assign load_word = {sra_half(rom_q_i[LEFT_MSB:LEFT_LSB], gain_shift_i),
                      sra_half(rom_q_i[RIGHT_MSB:RIGHT_LSB], gain_shift_i)};
`else
  assign load_word = rom_q_i;
`endif

  assign accept         = valid_q && ready_i;
  assign rom_addr_o     = addr_q;
  assign sample_o       = sample_q;
  assign valid_o        = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign underrun_cnt_o = under_q;

  tone_tick_div #(.DIV(CLK_DIV)) u_tick_div (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .en     (busy_o),
    .restart(div_restart),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    target_d    = target_q;
    loop_d      = loop_q;
    sample_d    = sample_q;
    valid_d     = valid_q && !accept;
    done_d      = 1'b0;
    under_d     = under_q;
    load        = 1'b0;
    div_restart = 1'b0;

    if (state_q != IDLE && stop_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d = '0;
          if (start_i) begin
            loop_d      = loop_i;
            target_d    = (rep_count_i == '0) ? REP_WIDTH'(1) : rep_count_i;
            pass_d      = '0;
            div_restart = 1'b1;
            state_d     = PRIME;
          end
        end
        PRIME: begin
          load    = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          // The pass count is bumped when the last word is loaded; the tick after that ends a finite run.
          if (tick) begin
            if (!loop_q && pass_q == target_q) begin
              state_d = DRAIN;
            end else begin
              load = 1'b1;
              if (!loop_q && addr_q == '1) begin
                pass_d = pass_q + REP_WIDTH'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!valid_q || accept) begin
            done_d  = 1'b1;
            addr_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        sample_d = load_word;
        valid_d  = 1'b1;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        if (valid_q && !accept && under_q != 16'hFFFF) begin
          under_d = under_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pass_q   <= '0;
      target_q <= '0;
      loop_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      under_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      target_q <= target_d;
      loop_q   <= loop_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      under_q  <= under_d;
    end
  end

endmodule

// File: tb/tb_tone_rom_player.sv
// tb/tb_tone_rom_player.sv - scoreboard bench for tone_rom_player with a tick-schedule reference model
module tb_tone_rom_player;

  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int DIV = 8;
  localparam int RW  = 8;
  localparam int TBL = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [RW-1:0] rep_count_i = '0;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_q_i;
  logic [DW-1:0] sample_o;
  logic          valid_o;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   underrun_cnt_o;
  logic          rom_override = 1'b0;
`ifdef TONE_ROM_PLAYER_GAIN_EN
  logic [3:0]    gain_shift_i = 4'd0;
`endif

  always #5 clk = ~clk;

  // Stand-in tone ROM: each word holds its own address.
  assign rom_q_i = rom_override ? 32'h8000_4000 : {{(DW-AW){1'b0}}, rom_addr_o};

  tone_rom_player #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CLK_DIV   (DIV),
    .REP_WIDTH (RW)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .loop_i        (loop_i),
    .rep_count_i   (rep_count_i),
    .rom_addr_o    (rom_addr_o),
    .rom_q_i       (rom_q_i),
`ifdef TONE_ROM_PLAYER_GAIN_EN
    .gain_shift_i  (gain_shift_i),
`endif
    .sample_o      (sample_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int dones = 0;
  int exp_q[$];

  bit m_busy = 0;
  bit m_loop = 0;
  bit m_valid = 0;
  bit m_drain = 0;
  int m_cyc = 0;
  int m_target = 1;
  int m_val = 0;
  int m_under = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Playback schedule: word 0 lands one edge after start, word k lands k*DIV edges after start.
  task automatic model_edge();
    bit acc;
    bit vb;
    int k;
    vb  = m_valid;
    acc = m_valid && ready_i;
    if (acc) begin
      exp_q.push_back(m_val);
      m_valid = 0;
    end
    if (!m_busy) begin
      if (start_i) begin
        m_busy   = 1;
        m_drain  = 0;
        m_cyc    = 0;
        m_loop   = loop_i;
        m_target = (rep_count_i == 0) ? 1 : int'(rep_count_i);
      end
      return;
    end
    if (stop_i) begin
      m_busy  = 0;
      m_drain = 0;
      m_valid = 0;
      return;
    end
    m_cyc++;
    if (m_drain) begin
      if (!m_valid) begin
        m_busy  = 0;
        m_drain = 0;
      end
      return;
    end
    if (m_cyc == 1) k = 0;
    else if (m_cyc % DIV == 0) k = m_cyc / DIV;
    else return;
    if (!m_loop && k >= TBL * m_target) begin
      m_drain = 1;
      return;
    end
    if (vb && !acc && m_under < 65535) m_under++;
    m_val   = k % TBL;
    m_valid = 1;
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
    check("valid", valid_o, m_valid);
    check("underrun", underrun_cnt_o, m_under);
    if (done_o) dones++;
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o === 1'b1 && ready_i) begin
      accepts++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got sample %0h expected no accept", sample_o);
      end else begin
        check("sample", sample_o, exp_q.pop_front());
      end
    end
  end

  task automatic run_finite(input int rep, input bit rnd, input int exp_acc);
    int n;
    accepts     = 0;
    dones       = 0;
    loop_i      = 0;
    rep_count_i = RW'(rep);
    ready_i     = 1;
    start_i     = 1;
    clk_step();
    start_i = 0;
    n = 0;
    while (busy_o && n < 4000) begin
      if (rnd) ready_i = ($urandom_range(0, 3) != 0);
      clk_step();
      n++;
    end
    check("finite_timeout", n < 4000, 1);
    ready_i = 1;
    repeat (3) clk_step();
    if (!rnd) check("finite_accepts", accepts, exp_acc);
    check("finite_done_pulses", dones, 1);
    check("finite_busy_low", busy_o, 0);
    check("finite_sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int u0;
    bit vflag;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sample", sample_o, 0);
    check("rst_addr", rom_addr_o, 0);
    check("rst_underrun", underrun_cnt_o, 0);
    rst = 0;

    // Continuous loop with ready tied high, across more than two table passes.
    ready_i = 1;
    loop_i  = 1;
    start_i = 1;
    clk_step();
    start_i = 0;
    check("prime_busy", busy_o, 1);
    repeat (2 * TBL * DIV + 40) clk_step();
    check("loop_no_underrun", underrun_cnt_o, 0);

    n = 0;
    while (!(m_valid && m_val == 50) && n < 1100) begin
      clk_step();
      n++;
    end
    check("reach_addr50", n < 1100, 1);
    stop_i = 1;
    clk_step();
    stop_i = 0;
    check("stop_busy", busy_o, 0);
    check("stop_valid", valid_o, 0);
    check("stop_done", done_o, 0);
    check("stop_addr", rom_addr_o, 0);

    start_i = 1;
    clk_step();
    start_i = 0;
    clk_step();
    check("restart_sample0", sample_o, 0);
    check("restart_addr1", rom_addr_o, 1);

    // Random backpressure in loop mode, with a start pulse that must be ignored.
    for (int i = 0; i < 800; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (i == 400) begin
        start_i = 1;
        loop_i  = 0;
      end
      clk_step();
      start_i = 0;
      loop_i  = 1;
    end
    ready_i = 1;
    repeat (4) clk_step();

    n = 0;
    while (!(m_valid && m_cyc % DIV == 0) && n < 50) begin
      clk_step();
      n++;
    end
    check("stall_align", n < 50, 1);
    ready_i = 0;
    u0      = int'(underrun_cnt_o);
    vflag   = 1;
    repeat (20) begin
      clk_step();
      if (valid_o !== 1'b1) vflag = 0;
    end
    check("stall_underrun_plus2", underrun_cnt_o, u0 + 2);
    check("stall_valid_held", vflag, 1);
    check("stall_latest_sample", sample_o, m_val);
    ready_i = 1;
    repeat (20) clk_step();

    #2;
    rst = 1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_sample", sample_o, 0);
    check("arst_addr", rom_addr_o, 0);
    check("arst_underrun", underrun_cnt_o, 0);
    m_busy  = 0;
    m_valid = 0;
    m_drain = 0;
    m_under = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 0;

    run_finite(2, 0, 2 * TBL);
    run_finite(0, 0, TBL);
    run_finite(int'($urandom_range(0, 1)), 1, 0);
    run_finite(int'($urandom_range(0, 1)), 1, 0);

`ifdef TONE_ROM_PLAYER_GAIN_EN
    rom_override = 1;
    gain_shift_i = 4'd2;
    ready_i      = 0;
    start_i      = 1;
    @(posedge clk);
    #1;
    start_i = 0;
    @(posedge clk);
    #1;
    check("gain_shift2", sample_o, 32'hE000_1000);
    stop_i = 1;
    @(posedge clk);
    #1;
    stop_i       = 0;
    rom_override = 0;
    gain_shift_i = 4'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
